regressive_counter: RTL and testbench

- Configurable countdown timer for the DE-board lab top level.
- Loads a 4-bit seconds value and decrements it once per second while `start` is high.
- Shows the remaining seconds on one active-low 7-segment digit (HEX5).
- Flags completion on LEDR9, then automatically reloads and counts again.

---
 rtl/regressive_counter.sv | 132 +++++++++++++
 tb/tb_regressive_counter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/regressive_counter.sv
// Countdown timer: loads a 4-bit seconds value, decrements once per second while
// start is high, drives an active-low 7-segment digit and a completion flag.
module regressive_counter #(
  parameter int CLOCKS_PER_SECOND = 50000000,
  parameter int PRESCALER_WIDTH   = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] seconds_period,
  input  logic       start,
  output logic [6:0] hex5_seconds_left,
  output logic       ledr9_finished
);

  localparam logic [PRESCALER_WIDTH-1:0] PRESCALE_LAST = PRESCALER_WIDTH'(CLOCKS_PER_SECOND - 1);
  localparam logic [PRESCALER_WIDTH-1:0] PRESCALE_ONE  = PRESCALER_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [PRESCALER_WIDTH-1:0] r_prescaler;
  logic [PRESCALER_WIDTH-1:0] w_prescaler_next;
  logic [3:0]                 r_count;
  logic [3:0]                 w_count_next;
  logic                       r_finished;
  logic                       w_finished_next;
  logic                       w_tick;

  // Active-low segment pattern, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7_decode(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'b1000000;
      4'h1:    pattern = 7'b1111001;
      4'h2:    pattern = 7'b0100100;
      4'h3:    pattern = 7'b0110000;
      4'h4:    pattern = 7'b0011001;
      4'h5:    pattern = 7'b0010010;
      4'h6:    pattern = 7'b0000010;
      4'h7:    pattern = 7'b1111000;
      4'h8:    pattern = 7'b0000000;
      4'h9:    pattern = 7'b0010000;
      4'hA:    pattern = 7'b0001000;
      4'hB:    pattern = 7'b0000011;
      4'hC:    pattern = 7'b1000110;
      4'hD:    pattern = 7'b0100001;
      4'hE:    pattern = 7'b0000110;
      4'hF:    pattern = 7'b0001110;
      default: pattern = 7'b1111111;
    endcase
    return pattern;
  endfunction

  // State, prescaler, count and finished-flag registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prescaler <= '0;
      r_count     <= seconds_period;
      r_finished  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_prescaler <= w_prescaler_next;
      r_count     <= w_count_next;
      r_finished  <= w_finished_next;
    end
  end

  // Next-state, prescaler and count logic.
  always_comb begin
    w_state_next     = r_state;
    w_prescaler_next = r_prescaler;
    w_count_next     = r_count;
    w_tick           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_prescaler_next = '0;
        w_count_next     = seconds_period;
        if (start) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!start) begin
          // Leaving RUN takes no tick, so the partial second is preserved.
          w_state_next = ST_PAUSE;
        end else begin
          w_state_next = ST_RUN;
          if (r_prescaler == PRESCALE_LAST) begin
            w_tick           = 1'b1;
            w_prescaler_next = '0;
          end else begin
            w_prescaler_next = r_prescaler + PRESCALE_ONE;
          end
          if (w_tick) begin
            if (r_count != 4'd0) begin
              w_count_next = r_count - 4'd1;
            end else begin
              w_count_next = seconds_period;
            end
          end else begin
            w_count_next = r_count;
          end
        end
      end
      ST_PAUSE: begin
        if (start) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_PAUSE;
        end
      end
      default: begin
        w_state_next     = ST_IDLE;
        w_prescaler_next = '0;
        w_count_next     = seconds_period;
      end
    endcase
    w_finished_next = (w_state_next != ST_IDLE) && (w_count_next == 4'd0);
  end

  assign hex5_seconds_left = seg7_decode(r_count);
  assign ledr9_finished    = r_finished;

endmodule

// File: tb/tb_regressive_counter.sv
// Scoreboard bench for regressive_counter: a run-time based reference model
// predicts each cycle's display and flag; a monitor compares them to the DUT.
module tb_regressive_counter;

  localparam int CPS = 2;
  localparam int PW  = 2;

  logic       clock;
  logic       reset;
  logic [3:0] seconds_period;
  logic       start;
  logic [6:0] hex5_seconds_left;
  logic       ledr9_finished;

  regressive_counter #(
    .CLOCKS_PER_SECOND(CPS),
    .PRESCALER_WIDTH  (PW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .seconds_period   (seconds_period),
    .start            (start),
    .hex5_seconds_left(hex5_seconds_left),
    .ledr9_finished   (ledr9_finished)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         cycle = 0;
  bit         done = 1'b0;
  logic [7:0] exp_q[$];
  logic [6:0] seg_tbl[16];

  // Model: mode 0 idle, 1 running, 2 paused; count derived from run cycles since load.
  int m_mode = 0;
  int m_latched = 0;
  int m_run_cycles = 0;

  task automatic step(input logic rst, input logic st, input logic [3:0] per);
    int exp_count;
    logic exp_led;
    reset = rst;
    start = st;
    seconds_period = per;
    if (rst) begin
      m_mode = 0;
      m_latched = int'(per);
      m_run_cycles = 0;
    end else if (m_mode == 0) begin
      m_latched = int'(per);
      m_run_cycles = 0;
      if (st) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!st) begin
        m_mode = 2;
      end else begin
        m_run_cycles++;
        // A period of N occupies N+1 full seconds before reloading.
        if (m_run_cycles == (m_latched + 1) * CPS) begin
          m_latched = int'(per);
          m_run_cycles = 0;
        end
      end
    end else begin
      if (st) m_mode = 1;
    end
    exp_count = m_latched - m_run_cycles / CPS;
    exp_led = (m_mode != 0) && (exp_count == 0);
    exp_q.push_back({exp_led, seg_tbl[exp_count]});
    @(negedge clock);
  endtask

  // Monitor: one expected entry per rising edge, sampled just after it.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clock);
      #1;
      cycle++;
      if (exp_q.size() == 0) begin
        if (!done) begin
          tests_failed++;
          $display("FAIL queue_empty cycle %0d: no expected entry", cycle);
        end
      end else begin
        e = exp_q.pop_front();
        tests_run++;
        if (hex5_seconds_left !== e[6:0]) begin
          tests_failed++;
          $display("FAIL hex5 cycle %0d: got %b expected %b", cycle, hex5_seconds_left, e[6:0]);
        end
        tests_run++;
        if (ledr9_finished !== e[7]) begin
          tests_failed++;
          $display("FAIL ledr9 cycle %0d: got %b expected %b", cycle, ledr9_finished, e[7]);
        end
      end
    end
  end

  initial begin
    seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
    seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
    seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
    seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000;
    seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
    seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
    seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001;
    seg_tbl[14] = 7'b0000110; seg_tbl[15] = 7'b0001110;

    // Reset and IDLE tracking of the period input.
    repeat (2) step(1'b1, 1'b0, 4'd5);
    step(1'b0, 1'b0, 4'd5);
    repeat (2) step(1'b0, 1'b0, 4'd9);
    // Full countdown from 5 through zero and reload.
    repeat (16) step(1'b0, 1'b1, 4'd5);
    // Pause mid-second and resume.
    repeat (3) step(1'b0, 1'b1, 4'd5);
    repeat (5) step(1'b0, 1'b0, 4'd5);
    repeat (6) step(1'b0, 1'b1, 4'd5);
    // Period zero: flag stays high in RUN and PAUSE.
    step(1'b1, 1'b0, 4'd0);
    repeat (8) step(1'b0, 1'b1, 4'd0);
    repeat (3) step(1'b0, 1'b0, 4'd0);
    repeat (3) step(1'b0, 1'b1, 4'd0);
    // Mid-run period change only takes effect at reload.
    step(1'b1, 1'b0, 4'd5);
    repeat (4) step(1'b0, 1'b1, 4'd5);
    repeat (14) step(1'b0, 1'b1, 4'd2);
    // Period 15 and reset in the middle of a run.
    step(1'b1, 1'b0, 4'd15);
    repeat (5) step(1'b0, 1'b1, 4'd15);
    step(1'b1, 1'b1, 4'd7);
    repeat (3) step(1'b0, 1'b0, 4'd7);

    // Random stimulus: sticky start, occasional period changes and resets.
    begin
      logic       r_st;
      logic [3:0] r_per;
      r_st = 1'b1;
      r_per = 4'd3;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0) r_st = ~r_st;
        if ($urandom_range(0, 19) == 0) r_per = 4'($urandom_range(0, 15));
        step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, r_st, r_per);
      end
    end

    #2;
    done = 1'b1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
